// File: rtl/carwash_pay_ctrl.sv
// -----------------------------------------------------------------------------
// carwash_pay_ctrl
//
// Payment and sequencing front end for the car wash washer. Raw coin and
// button inputs are synchronized and edge-detected. A saturating 4-bit coin
// credit pays for a program. Once paid, the block holds a one-hot program line
// and issues one `coin` step strobe every STEP_CYCLES clocks, one per wash
// step. It then pulses `reset_program` to return the washer to idle.
//
// Ports
//   clk                     system clock, rising edge
//   reset_n                 asynchronous active-low reset
//   coin_in                 raw coin acceptor level (async)
//   sel_basic/extra/plat    raw program buttons (async)
//   cancel                  raw cancel button (async)
//   basic_program,
//   extra_cleaning_program,
//   platinum_program        one-hot program select to washer
//   coin                    one-cycle step strobe to washer
//   reset_program           one-cycle washer reset pulse
//   credit                  unspent coin count (saturates at 15)
//   busy                    high in ARM / RUN / DONE
//   refund                  one-cycle pulse: credit returned on cancel
//   reject                  one-cycle pulse: coin refused, credit saturated
// -----------------------------------------------------------------------------
module carwash_pay_ctrl #(
    parameter int PRICE_BASIC = 2,
    parameter int PRICE_EXTRA = 3,
    parameter int PRICE_PLAT  = 5,
    parameter int STEPS_BASIC = 6,
    parameter int STEPS_EXTRA = 8,
    parameter int STEPS_PLAT  = 14,
    parameter int STEP_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       coin_in,
    input  logic       sel_basic,
    input  logic       sel_extra,
    input  logic       sel_plat,
    input  logic       cancel,
    output logic       basic_program,
    output logic       extra_cleaning_program,
    output logic       platinum_program,
    output logic       coin,
    output logic       reset_program,
    output logic [3:0] credit,
    output logic       busy,
    output logic       refund,
    output logic       reject
);

    localparam int TW   = $clog2(STEP_CYCLES);
    localparam int SMAX = (STEPS_PLAT > STEPS_EXTRA) ?
                          ((STEPS_PLAT > STEPS_BASIC) ? STEPS_PLAT : STEPS_BASIC) :
                          ((STEPS_EXTRA > STEPS_BASIC) ? STEPS_EXTRA : STEPS_BASIC);
    localparam int SW   = $clog2(SMAX + 1);

    localparam logic [TW-1:0] TMR_RELOAD = TW'(STEP_CYCLES - 1);
    localparam logic [3:0]    P_BASIC    = 4'(PRICE_BASIC);
    localparam logic [3:0]    P_EXTRA    = 4'(PRICE_EXTRA);
    localparam logic [3:0]    P_PLAT     = 4'(PRICE_PLAT);
    localparam logic [SW-1:0] N_BASIC    = SW'(STEPS_BASIC);
    localparam logic [SW-1:0] N_EXTRA    = SW'(STEPS_EXTRA);
    localparam logic [SW-1:0] N_PLAT     = SW'(STEPS_PLAT);

    // Program vector layout: {platinum, extra, basic}
    localparam logic [2:0] PG_BASIC = 3'b001;
    localparam logic [2:0] PG_EXTRA = 3'b010;
    localparam logic [2:0] PG_PLAT  = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // ---------------------------------------------------------------------
    // Input synchronizers: two flops for metastability, a third for edge
    // detect. Bit order {coin, basic, extra, plat, cancel}.
    // ---------------------------------------------------------------------
    logic [4:0] w_raw;
    logic [4:0] r_sync1, r_sync2, r_sync3;
    logic [4:0] w_edge;

    assign w_raw  = {coin_in, sel_basic, sel_extra, sel_plat, cancel};
    assign w_edge = r_sync2 & ~r_sync3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    logic w_coin_edge, w_basic_edge, w_extra_edge, w_plat_edge, w_cancel_edge;
    assign {w_coin_edge, w_basic_edge, w_extra_edge, w_plat_edge, w_cancel_edge} = w_edge;

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    state_t        r_state,  w_state_nxt;
    logic [3:0]    r_credit, w_credit_nxt;
    logic [2:0]    r_prog,   w_prog_nxt;
    logic [TW-1:0] r_timer,  w_timer_nxt;
    logic [SW-1:0] r_steps,  w_steps_nxt;
    logic          r_refund, w_refund_nxt;
    logic          r_reject, w_reject_nxt;
    logic          w_strobe;

    // A coin is always added before anything else in the cycle looks at
    // credit, so a same-cycle select sees the incremented value.
    logic [3:0] w_cred_inc;
    logic       w_cred_full;

    assign w_cred_full = (r_credit == 4'd15);
    assign w_cred_inc  = (w_coin_edge && !w_cred_full) ? r_credit + 4'd1 : r_credit;

    // Highest-priority pressed button decides; a lower button pressed in
    // the same cycle is not considered as a fallback.
    logic [2:0] w_sel_pg;
    logic [3:0] w_sel_price;

    always_comb begin
        w_sel_pg    = '0;
        w_sel_price = '0;
        if (w_plat_edge) begin
            w_sel_pg    = PG_PLAT;
            w_sel_price = P_PLAT;
        end else if (w_extra_edge) begin
            w_sel_pg    = PG_EXTRA;
            w_sel_price = P_EXTRA;
        end else if (w_basic_edge) begin
            w_sel_pg    = PG_BASIC;
            w_sel_price = P_BASIC;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state / datapath logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = w_cred_inc;
        w_prog_nxt   = r_prog;
        w_timer_nxt  = r_timer;
        w_steps_nxt  = r_steps;
        w_refund_nxt = 1'b0;
        w_reject_nxt = w_coin_edge && w_cred_full;
        w_strobe     = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_cancel_edge) begin
                    if (w_cred_inc != 4'd0) begin
                        w_credit_nxt = 4'd0;
                        w_refund_nxt = 1'b1;
                    end
                end else if (w_sel_pg != 3'b000 && w_cred_inc >= w_sel_price) begin
                    w_credit_nxt = w_cred_inc - w_sel_price;
                    w_prog_nxt   = w_sel_pg;
                    w_state_nxt  = S_ARM;
                end
            end

            S_ARM: begin
                if (w_cancel_edge) begin
                    w_prog_nxt  = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_timer_nxt = TMR_RELOAD;
                    unique case (r_prog)
                        PG_PLAT:  w_steps_nxt = N_PLAT;
                        PG_EXTRA: w_steps_nxt = N_EXTRA;
                        default:  w_steps_nxt = N_BASIC;
                    endcase
                    w_state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                // Cancel wins over a strobe due in the same cycle.
                if (w_cancel_edge) begin
                    w_prog_nxt  = '0;
                    w_state_nxt = S_DONE;
                end else if (r_timer == '0) begin
                    w_strobe    = 1'b1;
                    w_timer_nxt = TMR_RELOAD;
                    w_steps_nxt = r_steps - SW'(1);
                    if (r_steps == SW'(1)) begin
                        w_prog_nxt  = '0;
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_prog_nxt  = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_credit <= '0;
            r_prog   <= '0;
            r_timer  <= '0;
            r_steps  <= '0;
            r_refund <= 1'b0;
            r_reject <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_credit <= w_credit_nxt;
            r_prog   <= w_prog_nxt;
            r_timer  <= w_timer_nxt;
            r_steps  <= w_steps_nxt;
            r_refund <= w_refund_nxt;
            r_reject <= w_reject_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs. The strobe decodes straight from registers, so it lines up
    // with the cycle in which the timer reads zero while the program line
    // is still held.
    // ---------------------------------------------------------------------
    assign {platinum_program, extra_cleaning_program, basic_program} = r_prog;
    assign coin          = w_strobe;
    assign reset_program = (r_state == S_DONE);
    assign busy          = (r_state != S_IDLE);
    assign credit        = r_credit;
    assign refund        = r_refund;
    assign reject        = r_reject;

endmodule

// File: doc/carwash_pay_ctrl.md
# carwash_pay_ctrl

Payment and sequencing front end for the car wash controller. Accepts raw coin-mechanism pulses and customer buttons, keeps a saturating coin credit, and, once a program is paid for, drives the wash state machine's input interface. It holds the one-hot program-select line and issues one `coin` step strobe per wash step at a fixed cadence, then pulses `reset_program` to return the washer to its idle state.

## Interface
- PRICE_BASIC, 2: coins charged for basic program
- PRICE_EXTRA, 3: coins charged for extra cleaning program
- PRICE_PLAT, 5: coins charged for platinum program
- STEPS_BASIC, 6: step strobes issued for basic
- STEPS_EXTRA, 8: step strobes issued for extra cleaning
- STEPS_PLAT, 14: step strobes issued for platinum
- STEP_CYCLES, 50_000_000: clk cycles between step strobes (≥2)
- clk  in  1  single system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- coin_in  in  1  raw coin-acceptor level, asynchronous
- sel_basic, sel_extra, sel_plat  in  1 each  raw program buttons, asynchronous
- cancel  in  1  raw cancel button, asynchronous
- basic_program, extra_cleaning_program, platinum_program  out  1 each  one-hot program select to washer
- coin  out  1  one-cycle step strobe to washer
- reset_program  out  1  one-cycle washer reset pulse
- credit  out  4  current unspent coin count
- busy  out  1  high while a wash is armed or running
- refund  out  1  one-cycle pulse, credit returned on cancel
- reject  out  1  one-cycle pulse, coin refused (credit saturated)

## Operation
- Reset: all outputs 0, credit 0, state IDLE, synchronizer flops 0, timers 0.
- All five raw inputs pass through 2-flop synchronizers plus a third flop for rising-edge detect; only rising edges act. Levels held high do not repeat.
- Credit: 4-bit unsigned, saturates at 15. A coin edge with credit=15 leaves credit at 15 and pulses `reject`. Coins are accepted in every state, including during a wash (credit carries to the next wash).
- States: IDLE, ARM, RUN, DONE.
- IDLE: select edge with credit ≥ price → credit -= price, assert the matching program line, go ARM. Insufficient credit → ignored, no output change. Simultaneous select edges: platinum > extra > basic. Select edge and coin edge in the same cycle: coin is added first, price compared against the incremented (saturated) value. Cancel edge with credit>0 → credit=0, `refund` pulse; with credit=0 → no action. Cancel has priority over a same-cycle select.
- ARM: one cycle; load step timer with STEP_CYCLES-1 and step counter with the program's step count; go RUN.
- RUN: timer decrements each cycle; at 0 → `coin` high one cycle, step counter decrements, timer reloads. When the strobe for the last step issues, go DONE at the next edge. Select edges ignored.
- DONE: one cycle; program line low, `reset_program` high; go IDLE.
- Cancel edge in ARM or RUN: abort, go DONE (washer reset), no refund; any strobe due that same cycle is suppressed.
- `busy` = state is ARM, RUN, or DONE. Exactly one program line is high in ARM/RUN, none otherwise.

## Timing
- Input-to-action latency: a raw edge first sampled high at clk edge n takes effect (credit/state/outputs registered) at edge n+2.
- Select accepted at edge t: program line high from t; ARM t→t+1; first `coin` strobe in the cycle after edge t+STEP_CYCLES; subsequent strobes every STEP_CYCLES cycles.
- Last strobe in cycle after edge L: program line still high in that cycle; DONE (program low, `reset_program` high) after edge L+1; IDLE after edge L+2.
- Program line is stable for the whole of every strobe cycle; no strobe occurs outside RUN.
- Asynchronous reset mid-wash: outputs drop to 0 immediately, credit lost, no `reset_program` pulse generated.

## Test plan
- STEP_CYCLES=4: insert 2 coins, press sel_basic → credit 2→0, basic_program high, exactly 6 `coin` strobes 4 cycles apart, then one `reset_program` pulse, busy low.
- Credit 4, press sel_plat → ignored (credit 4, busy 0); add 1 coin and press sel_plat same cycle → accepted, credit 0, 14 strobes.
- Press sel_basic and sel_plat in the same cycle with credit 5 → platinum_program only, credit 0.
- Insert 16 coins → credit 15, one `reject` pulse on the 16th; cancel → `refund` pulse, credit 0.
- Start extra cleaning, cancel after 3rd strobe → no 4th strobe, `reset_program` next cycle, program line low, credit unchanged, no refund.
- Insert 3 coins during a running basic wash → credit 3 after wash ends; deassert reset_n mid-wash → all outputs 0 asynchronously.
